// File: rtl/pc_fetch_queue.sv
// Purpose: program counter plus a fall-through queue of fetched {pc, instr} pairs for decode.
// Latency: a fetched word is enqueued on the edge that fetches it and is visible to decode the next cycle.
// Backpressure: out_ready low holds the head; when full, fetch stalls unless a pop frees a slot that same cycle.
module pc_fetch_queue #(
  parameter int               DEPTH    = 4,
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  // Redirect targets are forced to word alignment by clearing the low two bits.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  // Queue storage is never reset: entries are only visible when count says so.
  logic [XLEN-1:0] ent_pc_q    [DEPTH];
  logic [XLEN-1:0] ent_instr_q [DEPTH];

  logic push;
  logic pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign imem_addr = pc_q;
  assign count     = count_q;
  assign out_pc    = ent_pc_q[head_q];
  assign out_instr = ent_instr_q[head_q];

  // Handshakes and next-state: a redirect overrides push, pop and the pc step.
  always_comb begin
    out_valid = (count_q != '0) & ~redirect_valid;
    pop       = out_valid & out_ready;
    push      = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | pop);

    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + XLEN'(4);
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: asynchronous reset returns to the boot pc with an empty queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Capture the pc and the same-cycle instruction word at the tail on each push.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_q[tail_q]    <= pc_q;
      ent_instr_q[tail_q] <= imem_rdata;
    end
  end

endmodule
